// File: rtl/sd_cmd_engine_if.sv
// Avalon-MM register bus used to program and observe sd_cmd_engine.
//   address    : register select (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit read data, combinational from address (zero wait states)
interface sd_cmd_engine_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/sd_cmd_engine.sv
// SD card CMD-line sequencer. Generates SD_CLK from clk with a programmable
// divider and shifts out a 48-bit command frame with a hardware CRC7. It can
// then capture a 48-bit response, and always finishes with trailing clocks.
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (CTRL/STATUS, ARG, CMDIDX, CLKDIV, RESP0, RESP1)
//   sd_clk       : SD card clock (idles low)
//   sd_cmd_out   : CMD drive value, sd_cmd_oe : CMD output enable
//   sd_cmd_in    : CMD line sampled value
//   irq          : level interrupt, done & irq_en
module sd_cmd_engine #(
  parameter int unsigned RESP_TIMEOUT = 64,
  parameter int unsigned TRAIL_CLKS   = 8,
  parameter int unsigned DIV_W        = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  sd_cmd_engine_if.slave bus,
  output logic           sd_clk,
  output logic           sd_cmd_out,
  output logic           sd_cmd_oe,
  input  logic           sd_cmd_in,
  output logic           irq
);

  localparam int unsigned FRAME_W = 48;
  localparam int unsigned CNT_A   = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned CNT_B   = $clog2(TRAIL_CLKS + 1);
  localparam int unsigned CNT_W0  = (CNT_A > 6) ? CNT_A : 6;
  localparam int unsigned CNT_W   = (CNT_B > CNT_W0) ? CNT_B : CNT_W0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_WAIT,
    S_RX,
    S_TRAIL,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [31:0]        arg;
  logic [5:0]         cmdidx;
  logic [DIV_W-1:0]   clkdiv;
  logic [DIV_W-1:0]   div_cnt;
  logic [FRAME_W-1:0] frame, frame_d;
  logic [FRAME_W-1:0] resp, resp_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               resp_en, resp_en_d;
  logic               done, done_d;
  logic               timeout, timeout_d;
  logic               irq_en, irq_en_d;
  logic               cmd_out_d, cmd_oe_d, irq_d;

  logic wr_c, wr_ctrl_c, busy_c, clk_run_c, tick_c, rise_c, fall_c;
  logic unused_c;

  assign wr_c      = bus.chipselect && !bus.write_n;
  assign wr_ctrl_c = wr_c && (bus.address == 3'd0);
  assign busy_c    = (state != S_IDLE);
  assign unused_c  = ^{resp[47], resp[0]};

  // CRC7 (x^7 + x^3 + 1, init 0) over the 40 header bits, MSB first
  function automatic logic [6:0] crc7_calc(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  // Register read mux
  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      3'd0:    bus.readdata = {28'b0, irq_en, timeout, done, busy_c};
      3'd1:    bus.readdata = arg;
      3'd2:    bus.readdata = 32'(cmdidx);
      3'd3:    bus.readdata = 32'(clkdiv);
      3'd4:    bus.readdata = resp[39:8];
      3'd5:    bus.readdata = {18'b0, resp[46:40], resp[7:1]};
      default: bus.readdata = '0;
    endcase
  end

  // Command parameters; frozen while a transaction is in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arg    <= '0;
      cmdidx <= '0;
      clkdiv <= '0;
    end else if (wr_c && !busy_c) begin
      if (bus.address == 3'd1) arg    <= bus.writedata;
      if (bus.address == 3'd2) cmdidx <= bus.writedata[5:0];
      if (bus.address == 3'd3) clkdiv <= bus.writedata[DIV_W-1:0];
    end
  end

  // SD clock divider: half-period is clkdiv+1 cycles, parked low when not sequencing
  assign clk_run_c = (state == S_TX) || (state == S_WAIT) ||
                     (state == S_RX) || (state == S_TRAIL);
  assign tick_c    = clk_run_c && (div_cnt == clkdiv);
  assign rise_c    = tick_c && !sd_clk;
  assign fall_c    = tick_c && sd_clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      sd_clk  <= 1'b0;
    end else if (!clk_run_c) begin
      div_cnt <= '0;
      sd_clk  <= 1'b0;
    end else if (tick_c) begin
      div_cnt <= '0;
      sd_clk  <= ~sd_clk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      frame      <= '0;
      resp       <= '0;
      cnt        <= '0;
      resp_en    <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      irq_en     <= 1'b0;
      sd_cmd_out <= 1'b1;
      sd_cmd_oe  <= 1'b0;
      irq        <= 1'b0;
    end else begin
      state      <= state_d;
      frame      <= frame_d;
      resp       <= resp_d;
      cnt        <= cnt_d;
      resp_en    <= resp_en_d;
      done       <= done_d;
      timeout    <= timeout_d;
      irq_en     <= irq_en_d;
      sd_cmd_out <= cmd_out_d;
      sd_cmd_oe  <= cmd_oe_d;
      irq        <= irq_d;
    end
  end

  // Next-state logic; clear is applied before the FSM so a same-write start wins
  always_comb begin
    state_d   = state;
    frame_d   = frame;
    resp_d    = resp;
    cnt_d     = cnt;
    resp_en_d = resp_en;
    done_d    = done;
    timeout_d = timeout;
    irq_en_d  = irq_en;
    cmd_out_d = sd_cmd_out;
    cmd_oe_d  = sd_cmd_oe;

    if (wr_ctrl_c) begin
      irq_en_d = bus.writedata[3];
      if (bus.writedata[2]) begin
        done_d    = 1'b0;
        timeout_d = 1'b0;
      end
    end

    unique case (state)
      S_IDLE: begin
        if (wr_ctrl_c && bus.writedata[0]) begin
          frame_d   = {2'b01, cmdidx, arg, crc7_calc({2'b01, cmdidx, arg}), 1'b1};
          resp_en_d = bus.writedata[1];
          done_d    = 1'b0;
          timeout_d = 1'b0;
          cmd_oe_d  = 1'b1;
          cmd_out_d = 1'b0;
          cnt_d     = CNT_W'(FRAME_W - 1);
          state_d   = S_TX;
        end
      end

      // frame[47] is always the bit on the wire; cnt is its frame index
      S_TX: begin
        if (fall_c) begin
          if (cnt == '0) begin
            cmd_oe_d  = 1'b0;
            cmd_out_d = 1'b1;
            state_d   = resp_en ? S_WAIT : S_TRAIL;
          end else begin
            frame_d   = {frame[FRAME_W-2:0], 1'b0};
            cmd_out_d = frame[FRAME_W-2];
            cnt_d     = cnt - CNT_W'(1);
          end
        end
      end

      // cnt counts rises spent waiting for the start bit
      S_WAIT: begin
        if (rise_c) begin
          if (!sd_cmd_in) begin
            resp_d[FRAME_W-1] = 1'b0;
            cnt_d             = CNT_W'(FRAME_W - 2);
            state_d           = S_RX;
          end else if (cnt == CNT_W'(RESP_TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_TRAIL;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end

      // cnt is the response bit index being captured
      S_RX: begin
        if (rise_c) begin
          resp_d[cnt[5:0]] = sd_cmd_in;
          if (cnt == '0) begin
            state_d = S_TRAIL;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
      end

      // cnt counts trailing rises; finish on the fall that returns sd_clk low
      S_TRAIL: begin
        if (rise_c) begin
          cnt_d = cnt + CNT_W'(1);
        end else if (fall_c && (cnt == CNT_W'(TRAIL_CLKS))) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    irq_d = done_d && irq_en_d;
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
`timescale 1ns/1ps
module tb_sd_cmd_engine;

  localparam int unsigned RESP_TIMEOUT = 64;
  localparam int unsigned TRAIL_CLKS   = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic sd_clk, sd_cmd_out, sd_cmd_oe, irq;
  logic sd_cmd_in = 1'b1;

  sd_cmd_engine_if bus();

  sd_cmd_engine #(
    .RESP_TIMEOUT(RESP_TIMEOUT),
    .TRAIL_CLKS  (TRAIL_CLKS),
    .DIV_W       (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .sd_clk    (sd_clk),
    .sd_cmd_out(sd_cmd_out),
    .sd_cmd_oe (sd_cmd_oe),
    .sd_cmd_in (sd_cmd_in),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Transaction monitor: wire bits at each rise, rises after host release, period
  int          txn_id     = 0;
  int          mon_txn    = -1;
  logic [47:0] tx_word    = '0;
  int          tx_n       = 0;
  int          post_rises = 0;
  int          n_rises    = 0;
  time         t_r0       = 0;
  time         t_r1       = 0;

  always @(posedge sd_clk) begin
    #1;
    if (mon_txn != txn_id) begin
      mon_txn    = txn_id;
      tx_word    = '0;
      tx_n       = 0;
      post_rises = 0;
      n_rises    = 0;
    end
    if (n_rises == 0) t_r0 = $time;
    else if (n_rises == 1) t_r1 = $time;
    n_rises++;
    if (sd_cmd_oe) begin
      tx_word = {tx_word[46:0], sd_cmd_out};
      tx_n++;
    end else begin
      post_rises++;
    end
  end

  // Card model: after card_delay post-release rises, drives its response on falls
  int          card_txn   = -1;
  int          card_idx   = 0;
  bit          card_en    = 1'b0;
  logic [47:0] card_resp  = '0;
  int          card_delay = 1;

  always @(negedge sd_clk) begin
    if (card_txn != txn_id) begin
      card_txn = txn_id;
      card_idx = 0;
    end
    if (card_en && post_rises >= card_delay && card_idx < 48) begin
      sd_cmd_in = card_resp[47 - card_idx];
      card_idx++;
    end else begin
      sd_cmd_in = 1'b1;
    end
  end

  logic [31:0] model_r0 = '0;
  logic [31:0] model_r1 = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1 d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  // Frame from first principles: CRC7 is the remainder of header*x^7 mod x^7+x^3+1
  function automatic logic [47:0] ref_frame(input logic [5:0] cmd, input logic [31:0] a);
    logic [39:0] head;
    logic [46:0] rem;
    logic [46:0] poly;
    head = {2'b01, cmd, a};
    rem  = {head, 7'b0};
    poly = 47'h89;
    for (int i = 46; i >= 7; i--)
      if (rem[i]) rem = rem ^ (poly << (i - 7));
    return {head, rem[6:0], 1'b1};
  endfunction

  task automatic run_txn(input logic [5:0] cmd, input logic [31:0] a, input logic [15:0] div,
                         input bit ren, input bit cen, input logic [47:0] rsp, input int dly,
                         input bit ien, input bit poke);
    logic [31:0] v;
    logic [47:0] exp_frame;
    int          exp_post;
    bit          exp_to;
    int          guard;
    exp_frame = ref_frame(cmd, a);
    exp_to    = ren && !cen;
    exp_post  = !ren ? int'(TRAIL_CLKS)
                     : (cen ? dly + 48 + int'(TRAIL_CLKS) : int'(RESP_TIMEOUT + TRAIL_CLKS));
    wr(3'd1, a);
    wr(3'd2, 32'(cmd));
    wr(3'd3, 32'(div));
    card_en    = cen;
    card_resp  = rsp;
    card_delay = dly;
    txn_id++;
    wr(3'd0, {28'b0, ien, 1'b0, ren, 1'b1});
    chk("start_oe", sd_cmd_oe, 1'b1);
    chk("start_bit", sd_cmd_out, 1'b0);
    if (poke) begin
      wr(3'd1, 32'hFFFF_FFFF);
      wr(3'd3, 32'd5);
      wr(3'd0, {28'b0, ien, 3'b001});
    end
    guard = 0;
    do begin
      rd(3'd0, v);
      guard++;
    end while (v[0] && guard < 20000);
    chk("busy_clear", v[0], 1'b0);
    chk("tx_bit_count", 64'(tx_n), 64'd48);
    chk("tx_frame", tx_word, exp_frame);
    chk("post_release_rises", 64'(post_rises), 64'(exp_post));
    chk("sd_clk_period", 64'(t_r1 - t_r0), 64'(2 * (int'(div) + 1) * 10));
    chk("status", 64'(v[3:0]), 64'({ien, exp_to, 1'b1, 1'b0}));
    chk("irq_pin", irq, ien);
    chk("idle_pins", {sd_clk, sd_cmd_oe, sd_cmd_out}, 3'b001);
    if (ren && cen) begin
      model_r0 = rsp[39:8];
      model_r1 = {18'b0, rsp[46:40], rsp[7:1]};
    end
    rd(3'd4, v);
    chk("resp0", v, model_r0);
    rd(3'd5, v);
    chk("resp1", v, model_r1);
    if (poke) begin
      rd(3'd1, v);
      chk("arg_protected", v, a);
      rd(3'd3, v);
      chk("clkdiv_protected", v, 32'(div));
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [5:0]  r_cmd;
    logic [31:0] r_arg;
    logic [15:0] r_div;
    bit          r_ren, r_cen, r_ien;
    logic [47:0] r_rsp;
    int          r_dly;
    int          guard;

    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pins", {sd_clk, sd_cmd_out, sd_cmd_oe, irq}, 4'b0100);
    bus.address = 3'd0;
    #1 chk("rst_status", bus.readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic CMD0, no response
    run_txn(6'd0, 32'd0, 16'd0, 1'b0, 1'b0, 48'd0, 1, 1'b0, 1'b0);
    chk("cmd0_frame_literal", tx_word, 48'h4000_0000_0095);

    // CMD8 with a card reply, plus writes attempted while busy
    run_txn(6'd8, 32'h0000_01AA, 16'd3, 1'b1, 1'b1, 48'h0800_0001_AA13, 5, 1'b0, 1'b1);
    chk("cmd8_frame_literal", tx_word, 48'h4800_0001_AA87);
    rd(3'd4, v);
    chk("cmd8_resp0_literal", v, 32'h0000_01AA);
    rd(3'd5, v);
    chk("cmd8_resp1_literal", v, 32'h0000_0409);

    // Response timeout with interrupt enabled, then clear
    run_txn(6'd17, 32'h1234_5678, 16'd1, 1'b1, 1'b0, 48'd0, 1, 1'b1, 1'b0);
    wr(3'd0, 32'h0000_000C);
    chk("clear_irq", irq, 1'b0);
    rd(3'd0, v);
    chk("clear_status", v, 32'h0000_0008);
    wr(3'd0, 32'h0000_0000);

    // Randomized transactions
    for (int k = 0; k < 6; k++) begin
      r_cmd = 6'($urandom);
      r_arg = $urandom;
      r_div = 16'($urandom_range(0, 3));
      r_ren = 1'($urandom_range(0, 1));
      r_cen = r_ren && ($urandom_range(0, 3) != 0);
      r_rsp = {2'b00, 6'($urandom), 32'($urandom), 7'($urandom), 1'b1};
      r_dly = int'($urandom_range(1, 30));
      r_ien = 1'($urandom_range(0, 1));
      run_txn(r_cmd, r_arg, r_div, r_ren, r_cen, r_rsp, r_dly, r_ien, 1'b0);
    end

    // Asynchronous reset in the middle of TX
    card_en = 1'b0;
    wr(3'd1, 32'hDEAD_BEEF);
    wr(3'd2, 32'd5);
    wr(3'd3, 32'd1);
    txn_id++;
    wr(3'd0, 32'h0000_0009);
    guard = 0;
    while (!(mon_txn == txn_id && n_rises >= 10) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_tx_oe", sd_cmd_oe, 1'b1);
    #3 reset_n = 1'b0;
    #1 chk("mid_rst_pins", {sd_clk, sd_cmd_out, sd_cmd_oe, irq}, 4'b0100);
    model_r0 = '0;
    model_r1 = '0;
    for (int a = 0; a < 6; a++) begin
      bus.address = 3'(a);
      #1 chk("mid_rst_reg", {3'(a), bus.readdata}, {3'(a), 32'd0});
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Recovery after reset
    run_txn(6'd55, 32'h0, 16'd0, 1'b1, 1'b1, 48'h3700_0001_2083, 2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
